// File: rtl/cache_mem_arbiter.sv
// Arbitrates the shared four-bank main memory between the I-cache and D-cache FSMs.
// Grants whole transactions round-robin and drains bank activity before a hand-over.
module cache_mem_arbiter #(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned BANKS     = 4,
  parameter int unsigned DRAIN_MAX = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [DATA_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_data_in,
  input  logic              i_wr,
  input  logic              i_rd,
  output logic              i_grant,
  output logic [DATA_W-1:0] i_data_out,
  output logic              i_stall,
  output logic              i_err,
  input  logic              d_req,
  input  logic [DATA_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_data_in,
  input  logic              d_wr,
  input  logic              d_rd,
  output logic              d_grant,
  output logic [DATA_W-1:0] d_data_out,
  output logic              d_stall,
  output logic              d_err,
  output logic [DATA_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_data_in,
  output logic              m_wr,
  output logic              m_rd,
  input  logic [DATA_W-1:0] m_data_out,
  input  logic              m_stall,
  input  logic [BANKS-1:0]  m_busy,
  input  logic              m_err,
  output logic              drain_err
);

  localparam int unsigned CNT_W = $clog2(DRAIN_MAX + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    OWN_I = 2'b01,
    OWN_D = 2'b10,
    DRAIN = 2'b11
  } state_t;

  state_t           state, state_n, release_st;
  logic             last_owner, last_owner_n;
  logic [CNT_W-1:0] drain_cnt, drain_cnt_n;
  logic             drain_err_n;
  logic             busy_any, other_req, owner_req;
  logic             i_act, d_act;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_owner <= 1'b0;
      drain_cnt  <= '0;
      drain_err  <= 1'b0;
    end else begin
      state      <= state_n;
      last_owner <= last_owner_n;
      drain_cnt  <= drain_cnt_n;
      drain_err  <= drain_err_n;
    end
  end

  // last_owner always names the current (or draining) owner outside IDLE
  always_comb begin
    state_n      = state;
    last_owner_n = last_owner;
    drain_cnt_n  = drain_cnt;
    drain_err_n  = 1'b0;
    busy_any     = |m_busy;
    other_req    = last_owner ? i_req : d_req;
    owner_req    = last_owner ? d_req : i_req;
    release_st   = other_req ? (last_owner ? OWN_I : OWN_D) : IDLE;

    case (state)
      IDLE: begin
        if (i_req && d_req) begin
          state_n      = last_owner ? OWN_I : OWN_D;
          last_owner_n = ~last_owner;
        end else if (d_req) begin
          state_n      = OWN_D;
          last_owner_n = 1'b1;
        end else if (i_req) begin
          state_n      = OWN_I;
          last_owner_n = 1'b0;
        end
      end
      OWN_I, OWN_D: begin
        if (!owner_req) begin
          if (!busy_any) begin
            state_n = release_st;
            if (other_req) last_owner_n = ~last_owner;
          end else begin
            state_n     = DRAIN;
            drain_cnt_n = '0;
          end
        end
      end
      DRAIN: begin
        if (!busy_any) begin
          state_n = release_st;
          if (other_req) last_owner_n = ~last_owner;
        end else if (drain_cnt == CNT_W'(DRAIN_MAX - 1)) begin
          state_n     = IDLE;
          drain_err_n = 1'b1;
          drain_cnt_n = '0;
        end else begin
          drain_cnt_n = drain_cnt + CNT_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign i_grant = (state == OWN_I);
  assign d_grant = (state == OWN_D);

  // Owner-side mux; a simultaneous rd+wr is blocked and flagged instead of forwarded
  always_comb begin
    m_addr     = '0;
    m_data_in  = '0;
    m_wr       = 1'b0;
    m_rd       = 1'b0;
    i_data_out = '0;
    d_data_out = '0;
    i_err      = 1'b0;
    d_err      = 1'b0;
    i_act      = i_grant & i_req;
    d_act      = d_grant & d_req;
    if (i_act) begin
      i_data_out = m_data_out;
      i_err      = m_err | (i_wr & i_rd);
      if (!(i_wr && i_rd)) begin
        m_addr    = i_addr;
        m_data_in = i_data_in;
        m_wr      = i_wr;
        m_rd      = i_rd;
      end
    end else if (d_act) begin
      d_data_out = m_data_out;
      d_err      = m_err | (d_wr & d_rd);
      if (!(d_wr && d_rd)) begin
        m_addr    = d_addr;
        m_data_in = d_data_in;
        m_wr      = d_wr;
        m_rd      = d_rd;
      end
    end
    i_stall = (i_req & ~i_grant) | (i_grant & m_stall);
    d_stall = (d_req & ~d_grant) | (d_grant & m_stall);
  end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Bench for cache_mem_arbiter: directed scenarios plus randomized traffic,
// every cycle compared against a transaction-level ownership model.
module tb_cache_mem_arbiter;

  localparam int unsigned DATA_W    = 16;
  localparam int unsigned BANKS     = 4;
  localparam int unsigned DRAIN_MAX = 8;

  logic              clk, rst;
  logic              i_req, i_wr, i_rd, d_req, d_wr, d_rd;
  logic [DATA_W-1:0] i_addr, i_data_in, d_addr, d_data_in, m_data_out;
  logic              m_stall, m_err;
  logic [BANKS-1:0]  m_busy;
  logic              i_grant, i_stall, i_err, d_grant, d_stall, d_err;
  logic [DATA_W-1:0] i_data_out, d_data_out, m_addr, m_data_in;
  logic              m_wr, m_rd, drain_err;

  cache_mem_arbiter #(.DATA_W(DATA_W), .BANKS(BANKS), .DRAIN_MAX(DRAIN_MAX)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_data_in(i_data_in), .i_wr(i_wr), .i_rd(i_rd),
    .i_grant(i_grant), .i_data_out(i_data_out), .i_stall(i_stall), .i_err(i_err),
    .d_req(d_req), .d_addr(d_addr), .d_data_in(d_data_in), .d_wr(d_wr), .d_rd(d_rd),
    .d_grant(d_grant), .d_data_out(d_data_out), .d_stall(d_stall), .d_err(d_err),
    .m_addr(m_addr), .m_data_in(m_data_in), .m_wr(m_wr), .m_rd(m_rd),
    .m_data_out(m_data_out), .m_stall(m_stall), .m_busy(m_busy), .m_err(m_err),
    .drain_err(drain_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Model: who holds the memory (0 none, 1 I, 2 D), whether it is being drained,
  // which side won most recently (prev_d), and how long the drain has lasted.
  int who = 0;
  bit draining = 0;
  bit prev_d = 0;
  int age = 0;
  bit derr = 0;
  bit model_ok = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic hand_over();
    int other;
    other = (who == 1) ? 2 : 1;
    if ((other == 1) ? i_req : d_req) begin
      who = other;
      prev_d = (other == 2);
    end else begin
      who = 0;
    end
    draining = 0;
  endtask

  task automatic model_step();
    if (rst) begin
      who = 0; draining = 0; prev_d = 0; age = 0; derr = 0; model_ok = 1;
    end else if (model_ok) begin
      derr = 0;
      if (who == 0) begin
        if (i_req && d_req) begin
          who = prev_d ? 1 : 2;
          prev_d = (who == 2);
        end else if (d_req) begin
          who = 2; prev_d = 1;
        end else if (i_req) begin
          who = 1; prev_d = 0;
        end
      end else if (!draining) begin
        if (!((who == 1) ? i_req : d_req)) begin
          if (m_busy == '0) hand_over();
          else begin draining = 1; age = 0; end
        end
      end else begin
        if (m_busy == '0) hand_over();
        else if (age == int'(DRAIN_MAX) - 1) begin
          derr = 1; who = 0; draining = 0;
        end else age++;
      end
    end
  endtask

  function automatic bit mg(input int side);
    return (who == side) && !draining;
  endfunction

  // One clock: compare all outputs with the model, then advance both across the edge.
  task automatic tick();
    bit gi, gd, ai, ad;
    logic [DATA_W-1:0] ea, ed;
    logic ew, er;
    #1;
    if (model_ok) begin
      gi = mg(1); gd = mg(2);
      ai = gi && i_req; ad = gd && d_req;
      ea = '0; ed = '0; ew = 0; er = 0;
      if (ai && !(i_wr && i_rd)) begin ea = i_addr; ed = i_data_in; ew = i_wr; er = i_rd; end
      if (ad && !(d_wr && d_rd)) begin ea = d_addr; ed = d_data_in; ew = d_wr; er = d_rd; end
      chk("i_grant", 32'(i_grant), 32'(gi));
      chk("d_grant", 32'(d_grant), 32'(gd));
      chk("m_addr", 32'(m_addr), 32'(ea));
      chk("m_data_in", 32'(m_data_in), 32'(ed));
      chk("m_wr", 32'(m_wr), 32'(ew));
      chk("m_rd", 32'(m_rd), 32'(er));
      chk("i_data_out", 32'(i_data_out), ai ? 32'(m_data_out) : 32'd0);
      chk("d_data_out", 32'(d_data_out), ad ? 32'(m_data_out) : 32'd0);
      chk("i_err", 32'(i_err), 32'(ai && (m_err || (i_wr && i_rd))));
      chk("d_err", 32'(d_err), 32'(ad && (m_err || (d_wr && d_rd))));
      chk("i_stall", 32'(i_stall), 32'((i_req && !gi) || (gi && m_stall)));
      chk("d_stall", 32'(d_stall), 32'((d_req && !gd) || (gd && m_stall)));
      chk("drain_err", 32'(drain_err), 32'(derr));
    end
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic clear_in();
    i_req = 0; i_wr = 0; i_rd = 0; i_addr = '0; i_data_in = '0;
    d_req = 0; d_wr = 0; d_rd = 0; d_addr = '0; d_data_in = '0;
    m_data_out = '0; m_stall = 0; m_busy = '0; m_err = 0;
  endtask

  task automatic do_reset();
    clear_in();
    rst = 1; tick(); tick(); rst = 0;
  endtask

  int first_n;
  int starts[$];
  bit pi, pd;
  int held_i, held_d;
  int len_i, len_d, gap_i, gap_d, busy_run;

  initial begin
    rst = 1;
    clear_in();
    @(negedge clk);
    do_reset();
    #1;
    chk("rst_i_grant", 32'(i_grant), 32'd0);
    chk("rst_d_grant", 32'(d_grant), 32'd0);
    chk("rst_drain_err", 32'(drain_err), 32'd0);

    // Tie after reset: D wins, I stalls while pending
    i_req = 1; d_req = 1; tick(); #1;
    chk("tie_d_grant", 32'(d_grant), 32'd1);
    chk("tie_i_grant", 32'(i_grant), 32'd0);
    chk("tie_i_stall", 32'(i_stall), 32'd1);

    d_rd = 1; d_addr = 16'h1A40; m_data_out = 16'hBEEF; #1;
    chk("rd_m_rd", 32'(m_rd), 32'd1);
    chk("rd_m_addr", 32'(m_addr), 32'h1A40);
    chk("rd_d_data", 32'(d_data_out), 32'hBEEF);
    chk("rd_i_data", 32'(i_data_out), 32'd0);
    tick();

    d_wr = 1; #1;
    chk("conf_m_wr", 32'(m_wr), 32'd0);
    chk("conf_m_rd", 32'(m_rd), 32'd0);
    chk("conf_d_err", 32'(d_err), 32'd1);
    tick();
    d_wr = 0; d_rd = 0; m_err = 1; #1;
    chk("merr_d_err", 32'(d_err), 32'd1);
    chk("merr_i_err", 32'(i_err), 32'd0);
    tick();
    m_err = 0; d_req = 0; tick(); #1;
    chk("handover_i_grant", 32'(i_grant), 32'd1);
    tick();

    // I releases with bank 1 busy for 3 cycles, D waits through the drain
    i_req = 0; d_req = 1; m_busy = 4'b0010; tick();
    i_rd = 1; #1;
    chk("drain_i_grant", 32'(i_grant), 32'd0);
    chk("drain_d_grant", 32'(d_grant), 32'd0);
    chk("drain_m_rd", 32'(m_rd), 32'd0);
    tick(); tick();
    i_rd = 0; m_busy = '0; tick(); #1;
    chk("post_drain_d_grant", 32'(d_grant), 32'd1);

    // Drain timeout: stuck bank forces release with a one-cycle drain_err
    d_req = 0; m_busy = 4'b0001; tick();
    first_n = -1;
    for (int n = 1; n <= 12; n++) begin
      tick(); #1;
      if (drain_err && first_n < 0) first_n = n;
    end
    chk("timeout_cycles", 32'(first_n), 32'd8);
    chk("timeout_i_grant", 32'(i_grant), 32'd0);
    chk("timeout_d_grant", 32'(d_grant), 32'd0);

    // Back-to-back 4-cycle transactions from both sides must alternate D,I,D,I
    do_reset();
    held_i = 0; held_d = 0; pi = 0; pd = 0;
    for (int c = 0; c < 50; c++) begin
      if (mg(1) && !pi) starts.push_back(1);
      if (mg(2) && !pd) starts.push_back(2);
      pi = mg(1); pd = mg(2);
      if (!i_req) i_req = 1;
      else if (mg(1)) begin if (held_i == 4) begin i_req = 0; held_i = 0; end else held_i++; end
      if (!d_req) d_req = 1;
      else if (mg(2)) begin if (held_d == 4) begin d_req = 0; held_d = 0; end else held_d++; end
      tick();
    end
    chk("alt_count_ge6", 32'(starts.size() >= 6), 32'd1);
    for (int k = 0; k < 6 && k < starts.size(); k++)
      chk("alt_order", 32'(starts[k]), (k % 2 == 0) ? 32'd2 : 32'd1);

    // Randomized traffic
    do_reset();
    len_i = 1; len_d = 1; gap_i = 0; gap_d = 0; busy_run = 0;
    for (int c = 0; c < 3000; c++) begin
      rst = (c == 1500);
      if (i_req) begin
        if (mg(1)) begin if (len_i == 0) begin i_req = 0; gap_i = $urandom_range(0, 3); end else len_i--; end
      end else if (gap_i > 0) gap_i--;
      else begin i_req = 1; len_i = $urandom_range(1, 5); end
      if (d_req) begin
        if (mg(2)) begin if (len_d == 0) begin d_req = 0; gap_d = $urandom_range(0, 3); end else len_d--; end
      end else if (gap_d > 0) gap_d--;
      else begin d_req = 1; len_d = $urandom_range(1, 5); end
      i_rd = ($urandom_range(0, 2) == 0); i_wr = ($urandom_range(0, 2) == 0);
      d_rd = ($urandom_range(0, 2) == 0); d_wr = ($urandom_range(0, 2) == 0);
      i_addr = 16'($urandom); i_data_in = 16'($urandom);
      d_addr = 16'($urandom); d_data_in = 16'($urandom);
      m_data_out = 16'($urandom);
      m_stall = ($urandom_range(0, 3) == 0);
      m_err = ($urandom_range(0, 15) == 0);
      if (busy_run > 0) busy_run--;
      else if ($urandom_range(0, 5) == 0) busy_run = $urandom_range(1, 12);
      m_busy = (busy_run > 0) ? 4'($urandom_range(1, 15)) : 4'd0;
      tick();
    end
    rst = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
